// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit and its queue.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam int unsigned IMEM_BYTES_DEFAULT = 4096;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Decoder-side valid/ready handshake carrying one fetched instruction entry.
interface fetch_if;
    import fetch_pkg::*;

    logic         valid;
    logic         ready;
    fetch_entry_t entry;

    modport master (output valid, output entry, input ready);
    modport slave  (input valid, input entry, output ready);
endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries; dequeues on the decoder handshake, flush wins over push/pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         flush_i,
    input  fetch_entry_t wdata_i,
    output logic         full_o,
    output logic         empty_o,
    fetch_if.master      deq
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW:0]   count_q, count_d;
    fetch_entry_t  mem_q [DEPTH];
    logic          pop;
    logic          push;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign pop     = deq.valid & deq.ready;
    assign push    = push_i & (~full_o | pop);

    assign deq.valid = ~empty_o;
    assign deq.entry = mem_q[rptr_q];

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Storage is cleared on reset so the head reads as zero while reset is held.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push && !flush_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, redirect/enqueue control and range check feeding fetch_queue.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int unsigned QUEUE_DEPTH = 2,
    parameter int unsigned IMEM_BYTES  = IMEM_BYTES_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [31:0] instr_addr_o,
    input  logic [31:0] instr_rdata_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_fault_o
);

    logic [31:0]  pc_q, pc_d;
    logic         full;
    logic         empty;
    logic         push;
    logic         handshake;
    fetch_entry_t wentry;

    fetch_if u_deq ();

    assign u_deq.ready   = instr_ready_i;
    assign instr_valid_o = u_deq.valid;
    assign instr_o       = u_deq.entry.instr;
    assign instr_pc_o    = u_deq.entry.pc;
    assign instr_fault_o = u_deq.entry.fault;

    assign instr_addr_o = pc_q;
    assign handshake    = u_deq.valid & instr_ready_i;
    // A full queue still accepts a new word when the head leaves at the same edge.
    assign push         = ~jump_i & (~full | handshake);

    assign wentry.pc    = pc_q;
    assign wentry.instr = instr_rdata_i;
    assign wentry.fault = (pc_q >= 32'(IMEM_BYTES));

    always_comb begin
        pc_d = pc_q;
        if (jump_i) pc_d = jump_target_i & ~32'd3;
        else if (push) pc_d = pc_q + 32'd4;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pc_q <= RESET_PC;
        else         pc_q <= pc_d;
    end

    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .flush_i (jump_i),
        .wdata_i (wentry),
        .full_o  (full),
        .empty_o (empty),
        .deq     (u_deq)
    );

    logic unused_empty;
    assign unused_empty = empty;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table-driven cycle vectors plus reset and deep-queue sequences.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // DUT 1: default parameters
    logic        rst1_n, jump1;
    logic [31:0] addr1, rdata1, target1, instr1, pc1;
    logic        fault1;
    fetch_if     dec1 ();

    assign rdata1     = (addr1 < 32'd4096) ? addr1 : 32'd0;
    assign dec1.entry = {pc1, instr1, fault1};

    fetch_unit u_dut1 (
        .clk_i         (clk),
        .rst_ni        (rst1_n),
        .instr_addr_o  (addr1),
        .instr_rdata_i (rdata1),
        .jump_i        (jump1),
        .jump_target_i (target1),
        .instr_valid_o (dec1.valid),
        .instr_ready_i (dec1.ready),
        .instr_o       (instr1),
        .instr_pc_o    (pc1),
        .instr_fault_o (fault1)
    );

    // DUT 2: deeper queue, non-zero reset PC, small memory
    logic        rst2_n, jump2;
    logic [31:0] addr2, rdata2, target2, instr2, pc2;
    logic        fault2;
    fetch_if     dec2 ();

    assign rdata2     = (addr2 < 32'h90) ? addr2 : 32'd0;
    assign dec2.entry = {pc2, instr2, fault2};

    fetch_unit #(.RESET_PC(32'h80), .QUEUE_DEPTH(4), .IMEM_BYTES(32'h90)) u_dut2 (
        .clk_i         (clk),
        .rst_ni        (rst2_n),
        .instr_addr_o  (addr2),
        .instr_rdata_i (rdata2),
        .jump_i        (jump2),
        .jump_target_i (target2),
        .instr_valid_o (dec2.valid),
        .instr_ready_i (dec2.ready),
        .instr_o       (instr2),
        .instr_pc_o    (pc2),
        .instr_fault_o (fault2)
    );

    typedef struct {
        logic        ready;
        logic        jump;
        logic [31:0] target;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic        exp_fault;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst1_n = 1'b0; jump1 = 1'b0; target1 = '0; dec1.ready = 1'b0;
        rst2_n = 1'b0; jump2 = 1'b0; target2 = '0; dec2.ready = 1'b0;

        //          ready jump target        valid pc            instr         fault addr
        vq.push_back('{1, 0, 32'h0,         1, 32'h0,        32'h0,        0, 32'h4});
        vq.push_back('{1, 0, 32'h0,         1, 32'h4,        32'h4,        0, 32'h8});
        vq.push_back('{1, 0, 32'h0,         1, 32'h8,        32'h8,        0, 32'hC});
        vq.push_back('{0, 0, 32'h0,         1, 32'h8,        32'h8,        0, 32'h10});
        vq.push_back('{0, 0, 32'h0,         1, 32'h8,        32'h8,        0, 32'h10});
        vq.push_back('{0, 0, 32'h0,         1, 32'h8,        32'h8,        0, 32'h10});
        vq.push_back('{0, 0, 32'h0,         1, 32'h8,        32'h8,        0, 32'h10});
        vq.push_back('{0, 0, 32'h0,         1, 32'h8,        32'h8,        0, 32'h10});
        vq.push_back('{1, 0, 32'h0,         1, 32'hC,        32'hC,        0, 32'h14});
        vq.push_back('{1, 0, 32'h0,         1, 32'h10,       32'h10,       0, 32'h18});
        vq.push_back('{1, 0, 32'h0,         1, 32'h14,       32'h14,       0, 32'h1C});
        vq.push_back('{1, 1, 32'h103,       0, 32'h0,        32'h0,        0, 32'h100});
        vq.push_back('{1, 0, 32'h0,         1, 32'h100,      32'h100,      0, 32'h104});
        vq.push_back('{1, 0, 32'h0,         1, 32'h104,      32'h104,      0, 32'h108});
        vq.push_back('{1, 1, 32'hFFC,       0, 32'h0,        32'h0,        0, 32'hFFC});
        vq.push_back('{1, 0, 32'h0,         1, 32'hFFC,      32'hFFC,      0, 32'h1000});
        vq.push_back('{1, 0, 32'h0,         1, 32'h1000,     32'h0,        1, 32'h1004});
        vq.push_back('{1, 1, 32'hFFFF_FFFF, 0, 32'h0,        32'h0,        0, 32'hFFFF_FFFC});
        vq.push_back('{1, 0, 32'h0,         1, 32'hFFFF_FFFC, 32'h0,       1, 32'h0});
        vq.push_back('{1, 0, 32'h0,         1, 32'h0,        32'h0,        0, 32'h4});
        vq.push_back('{0, 0, 32'h0,         1, 32'h0,        32'h0,        0, 32'h8});
        vq.push_back('{0, 0, 32'h0,         1, 32'h0,        32'h0,        0, 32'h8});

        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(dec1.valid), 32'h0);
        chk("rst_instr", instr1, 32'h0);
        chk("rst_pc",    pc1,    32'h0);
        chk("rst_fault", 32'(fault1), 32'h0);
        chk("rst_addr",  addr1,  32'h0);

        rst1_n = 1'b1;
        foreach (vq[i]) begin
            dec1.ready = vq[i].ready;
            jump1      = vq[i].jump;
            target1    = vq[i].target;
            step();
            chk($sformatf("v%0d_valid", i), 32'(dec1.valid), 32'(vq[i].exp_valid));
            chk($sformatf("v%0d_addr", i), addr1, vq[i].exp_addr);
            if (vq[i].exp_valid) begin
                chk($sformatf("v%0d_pc", i), pc1, vq[i].exp_pc);
                chk($sformatf("v%0d_instr", i), instr1, vq[i].exp_instr);
                chk($sformatf("v%0d_fault", i), 32'(fault1), 32'(vq[i].exp_fault));
            end
        end

        // Asynchronous reset while the queue is full and stalled.
        #2 rst1_n = 1'b0;
        #1;
        chk("arst_valid", 32'(dec1.valid), 32'h0);
        chk("arst_addr",  addr1,  32'h0);
        chk("arst_instr", instr1, 32'h0);
        chk("arst_pc",    pc1,    32'h0);
        @(negedge clk);
        rst1_n = 1'b1; dec1.ready = 1'b1;
        step();
        chk("rel_pc0", pc1, 32'h0);
        chk("rel_addr0", addr1, 32'h4);
        step();
        chk("rel_pc1", pc1, 32'h4);
        chk("rel_instr1", instr1, 32'h4);

        // Depth-4 buffering, then drain through the memory boundary.
        rst2_n = 1'b1; dec2.ready = 1'b0;
        repeat (6) step();
        chk("d4_valid", 32'(dec2.valid), 32'h1);
        chk("d4_head",  pc2,   32'h80);
        chk("d4_addr",  addr2, 32'h90);
        dec2.ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] epc;
            epc = 32'h84 + 32'(4 * i);
            step();
            chk($sformatf("d4_pc%0d", i), pc2, epc);
            chk($sformatf("d4_instr%0d", i), instr2, (epc < 32'h90) ? epc : 32'h0);
            chk($sformatf("d4_fault%0d", i), 32'(fault2), (epc >= 32'h90) ? 32'h1 : 32'h0);
            chk($sformatf("d4_addr%0d", i), addr2, 32'h94 + 32'(4 * i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
